// File: rtl/bin2seg_seq_if.sv
// bin2seg_seq_if: start/done handshake and display bus for bin2seg_seq.
// The master side requests conversions; the slave side is the converter.
`timescale 1ns/1ps

interface bin2seg_seq_if #(
  parameter int IN_W = 7,
  parameter int NDIG = 2
);

  logic              start;
  logic [IN_W-1:0]   bin_in;
  logic              busy;
  logic              done;
  logic [8*NDIG-1:0] seg;
  logic              gt_max;

  modport master (
    output start,
    output bin_in,
    input  busy,
    input  done,
    input  seg,
    input  gt_max
  );

  modport slave (
    input  start,
    input  bin_in,
    output busy,
    output done,
    output seg,
    output gt_max
  );

endinterface

// File: rtl/bin2seg_seq.sv
// bin2seg_seq: multi-cycle binary to 7-segment driver. Converts an IN_W-bit
// unsigned value into NDIG BCD digits with sequential double-dabble (one shift
// per clock) and drives active-low segment patterns, DP held off.
// Optional build macro: BLANK_LZ_EN -- when defined, leading-zero digits above
// the ones digit are blanked; the overflow dash display is unaffected.
`timescale 1ns/1ps

module bin2seg_seq #(
  parameter int IN_W = 7,
  parameter int NDIG = 2
) (
  input  logic         clk,
  input  logic         reset,
  bin2seg_seq_if.slave bus
);

  // Returns 10^n as a 64-bit constant; used to size the overflow threshold.
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int k = 0; k < n; k++) begin
      p = p * 64'd10;
    end
    return p;
  endfunction

  localparam int          BCD_W     = 4 * NDIG;
  localparam int          CAT_W     = BCD_W + IN_W;
  localparam int          CNT_W     = $clog2(IN_W + 1);
  localparam logic [63:0] MAXV      = pow10(NDIG) - 64'd1;
  localparam logic [63:0] INMAX     = (64'd1 << IN_W) - 64'd1;
  localparam bit          OVF_REACH = (INMAX > MAXV);

  localparam logic [7:0] PAT_DASH  = 8'hBF;
  localparam logic [7:0] PAT_BLANK = 8'hFF;
  localparam logic [7:0] PAT_ZERO  = 8'hC0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    OUT   = 2'd2
  } state_t;

  // Active-low segment pattern for one BCD digit; DP bit 7 always off.
  function automatic logic [7:0] seg_pat(input logic [3:0] d);
    logic [7:0] p;
    case (d)
      4'd0:    p = 8'hC0;
      4'd1:    p = 8'hF9;
      4'd2:    p = 8'hA4;
      4'd3:    p = 8'hB0;
      4'd4:    p = 8'h99;
      4'd5:    p = 8'h92;
      4'd6:    p = 8'h82;
      4'd7:    p = 8'hF8;
      4'd8:    p = 8'h80;
      4'd9:    p = 8'h98;
      default: p = PAT_BLANK;
    endcase
    return p;
  endfunction

  state_t            state;
  logic [IN_W-1:0]   bin_q;
  logic [BCD_W-1:0]  bcd_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              ovf_q;
  logic              busy_q;
  logic              done_q;
  logic [8*NDIG-1:0] seg_q;
  logic              gt_q;

  logic [BCD_W-1:0]  bcd_adj;
  logic [CAT_W-1:0]  cat_shift;
  logic [BCD_W-1:0]  bcd_shift;
  logic [IN_W-1:0]   bin_shift;
  logic [8*NDIG-1:0] seg_norm;
  logic [8*NDIG-1:0] seg_dash;
  logic              in_ovf;
`ifdef BLANK_LZ_EN
  logic              lead;
`endif

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.seg    = seg_q;
  assign bus.gt_max = gt_q;

  // Values above the largest displayable number skip the shift phase.
  assign in_ovf = OVF_REACH && (64'(bus.bin_in) > MAXV);

  assign seg_dash = {NDIG{PAT_DASH}};

  // One double-dabble step: add 3 to nibbles >= 5, then shift {bcd, bin} left.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NDIG; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    cat_shift = {bcd_adj, bin_q} << 1;
    bcd_shift = cat_shift[CAT_W-1:IN_W];
    bin_shift = cat_shift[IN_W-1:0];
  end

  // Decode the finished BCD register into segment patterns, most-significant first.
  always_comb begin
    seg_norm = '0;
`ifdef BLANK_LZ_EN
    lead = 1'b1;
`endif
    for (int i = NDIG - 1; i >= 0; i--) begin
      seg_norm[8*i +: 8] = seg_pat(bcd_q[4*i +: 4]);
`ifdef BLANK_LZ_EN
      if ((i != 0) && lead && (bcd_q[4*i +: 4] == 4'd0)) begin
        seg_norm[8*i +: 8] = PAT_BLANK;
      end else begin
        lead = 1'b0;
      end
`endif
    end
  end

  // Control FSM: capture, shift IN_W times, then publish results for one done cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      seg_q  <= {NDIG{PAT_ZERO}};
      gt_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            bin_q  <= bus.bin_in;
            bcd_q  <= '0;
            cnt_q  <= CNT_W'(IN_W);
            busy_q <= 1'b1;
            if (in_ovf) begin
              ovf_q <= 1'b1;
              state <= OUT;
            end else begin
              ovf_q <= 1'b0;
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          bcd_q <= bcd_shift;
          bin_q <= bin_shift;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state <= OUT;
          end
        end
        OUT: begin
          if (ovf_q) begin
            seg_q <= seg_dash;
            gt_q  <= 1'b1;
          end else begin
            seg_q <= seg_norm;
            gt_q  <= 1'b0;
          end
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin2seg_seq.sv
// tb_bin2seg_seq: scoreboard bench for bin2seg_seq. Two instances are driven:
// the default 7-bit/2-digit build and a 10-bit/3-digit build. Expected results
// come from a decimal arithmetic model and are queued at the capture edge; a
// monitor per instance pops and compares whenever done is seen.
`timescale 1ns/1ps

module tb_bin2seg_seq;

  localparam logic [7:0] PAT [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                      8'h92, 8'h82, 8'hF8, 8'h80, 8'h98};

  typedef struct {
    logic [63:0]     seg;
    bit              gt;
    longint unsigned done_edge;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  longint unsigned cyc = 0;
  longint unsigned free_at [2];
  exp_t q0 [$];
  exp_t q1 [$];
  int checks = 0;
  int errors = 0;

  bin2seg_seq_if #(.IN_W(7),  .NDIG(2)) bus7 ();
  bin2seg_seq_if #(.IN_W(10), .NDIG(3)) bus10 ();

  bin2seg_seq #(.IN_W(7), .NDIG(2)) dut7 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus7)
  );

  bin2seg_seq #(.IN_W(10), .NDIG(3)) dut10 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus10)
  );

  // Free-running clock and edge counter used for latency bookkeeping.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Largest value representable with ndig decimal digits.
  function automatic longint unsigned maxOf(input int ndig);
    longint unsigned p;
    p = 1;
    for (int k = 0; k < ndig; k++) p = p * 10;
    return p - 1;
  endfunction

  // Expected display for value v: decimal digits by division, dashes on overflow.
  function automatic logic [63:0] modelSeg(input longint unsigned v, input int ndig);
    logic [63:0] r;
    longint unsigned pw;
    logic [7:0] p;
    r = '0;
    pw = 1;
    if (v > maxOf(ndig)) begin
      for (int i = 0; i < ndig; i++) r[8*i +: 8] = 8'hBF;
    end else begin
      for (int i = 0; i < ndig; i++) begin
        p = PAT[int'((v / pw) % 10)];
`ifdef BLANK_LZ_EN
        if (i > 0 && v < pw) p = 8'hFF;
`endif
        r[8*i +: 8] = p;
        pw = pw * 10;
      end
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at edge %0d", name, act, exp, cyc);
    end
  endtask

  // Drive one cycle of inputs and predict whether the next edge captures.
  task automatic applyStimulus(input int which, input bit st, input longint unsigned val, input bit rst);
    longint unsigned v;
    longint unsigned upcoming;
    int inw;
    int ndig;
    exp_t e;
    reset = rst;
    bus7.start   = (which == 0) && st;
    bus7.bin_in  = 7'(val);
    bus10.start  = (which == 1) && st;
    bus10.bin_in = 10'(val);
    inw  = (which == 0) ? 7 : 10;
    ndig = (which == 0) ? 2 : 3;
    upcoming = cyc + 1;
    if (rst) begin
      q0.delete();
      q1.delete();
      free_at[0] = upcoming + 1;
      free_at[1] = upcoming + 1;
    end else if (st && upcoming >= free_at[which]) begin
      v = val % (64'd1 << inw);
      e.seg = modelSeg(v, ndig);
      e.gt = (v > maxOf(ndig));
      e.done_edge = upcoming + (e.gt ? 1 : inw + 1);
      free_at[which] = e.done_edge + 1;
      if (which == 0) q0.push_back(e);
      else q1.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(0, 1'b0, 0, 1'b0);
  endtask

  // Monitor for the 7-bit instance: every done must match the oldest prediction.
  always @(negedge clk) begin
    exp_t e;
    if (bus7.done === 1'b1) begin
      if (q0.size() == 0) begin
        checkOutput("unexpected_done7", 64'(bus7.done), 64'd0);
      end else begin
        e = q0.pop_front();
        checkOutput("seg7", 64'(bus7.seg), e.seg);
        checkOutput("gt7", 64'(bus7.gt_max), 64'(e.gt));
        checkOutput("lat7", cyc, e.done_edge);
        checkOutput("busy_done7", 64'(bus7.busy), 64'd0);
      end
    end
  end

  // Monitor for the 10-bit instance.
  always @(negedge clk) begin
    exp_t e;
    if (bus10.done === 1'b1) begin
      if (q1.size() == 0) begin
        checkOutput("unexpected_done10", 64'(bus10.done), 64'd0);
      end else begin
        e = q1.pop_front();
        checkOutput("seg10", 64'(bus10.seg), e.seg);
        checkOutput("gt10", 64'(bus10.gt_max), 64'(e.gt));
        checkOutput("lat10", cyc, e.done_edge);
      end
    end
  end

  // Hard stop if the sequence never completes.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at edge %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  // Directed and randomized sequence for both instances.
  initial begin
    free_at[0] = 0;
    free_at[1] = 0;
    reset = 1'b1;
    bus7.start = 1'b0;
    bus7.bin_in = '0;
    bus10.start = 1'b0;
    bus10.bin_in = '0;
    applyStimulus(0, 1'b0, 0, 1'b1);
    applyStimulus(0, 1'b1, 57, 1'b1);
    checkOutput("rst_seg7", 64'(bus7.seg), 64'hC0C0);
    checkOutput("rst_seg10", 64'(bus10.seg), 64'hC0C0C0);
    checkOutput("rst_busy7", 64'(bus7.busy), 64'd0);
    checkOutput("rst_done7", 64'(bus7.done), 64'd0);
    checkOutput("rst_gt7", 64'(bus7.gt_max), 64'd0);
    idle(1);

    applyStimulus(0, 1'b1, 57, 1'b0);
    checkOutput("busy_run7", 64'(bus7.busy), 64'd1);
    idle(10);

    applyStimulus(0, 1'b1, 99, 1'b0);
    idle(8);
    applyStimulus(0, 1'b1, 100, 1'b0);
    idle(4);

    applyStimulus(0, 1'b1, 0, 1'b0);
    idle(10);
    applyStimulus(0, 1'b1, 5, 1'b0);
    idle(10);

    for (int k = 0; k < 60; k++) begin
      applyStimulus(0, 1'($urandom_range(0, 1)), $urandom_range(0, 127), 1'b0);
    end
    idle(10);

    for (int k = 0; k < 20; k++) begin
      applyStimulus(0, 1'b1, $urandom_range(0, 127), 1'b0);
    end
    idle(10);

    applyStimulus(0, 1'b1, 57, 1'b0);
    idle(10);
    applyStimulus(0, 1'b1, 42, 1'b0);
    idle(3);
    applyStimulus(0, 1'b0, 0, 1'b1);
    checkOutput("abort_seg7", 64'(bus7.seg), 64'hC0C0);
    checkOutput("abort_busy7", 64'(bus7.busy), 64'd0);
    checkOutput("abort_done7", 64'(bus7.done), 64'd0);
    idle(10);
    applyStimulus(0, 1'b1, 42, 1'b0);
    idle(10);

    applyStimulus(1, 1'b1, 999, 1'b0);
    idle(13);
    applyStimulus(1, 1'b1, 1000, 1'b0);
    idle(4);
    applyStimulus(1, 1'b1, 0, 1'b0);
    idle(13);
    for (int k = 0; k < 40; k++) begin
      applyStimulus(1, 1'($urandom_range(0, 1)), $urandom_range(0, 1023), 1'b0);
    end

    for (int k = 0; k < 40 && (q0.size() + q1.size()) != 0; k++) idle(1);
    checkOutput("drain", 64'(q0.size() + q1.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
